// File: rtl/led_pattern_ctrl.sv
// LED pattern register with write/set/clear/toggle updates and a prescaled
// animation engine (static, rotate-left, rotate-right, blink).
module led_pattern_ctrl #(
  parameter int unsigned      WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = 16'h0001,
  parameter int unsigned      TICK_DIV  = 50_000_000,
  parameter int unsigned      CNT_W     = 26
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] D,
  input  logic             LD,
  input  logic [1:0]       OP,
  input  logic [1:0]       MODE_D,
  input  logic             MODE_LD,
  output logic [WIDTH-1:0] led,
  output logic [1:0]       mode,
  output logic             tick
);

  typedef enum logic [1:0] {
    OP_WRITE  = 2'b00,
    OP_SET    = 2'b01,
    OP_CLEAR  = 2'b10,
    OP_TOGGLE = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    M_STATIC = 2'b00,
    M_ROL    = 2'b01,
    M_ROR    = 2'b10,
    M_BLINK  = 2'b11
  } mode_e;

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);

  logic [WIDTH-1:0] pattern;
  logic [WIDTH-1:0] ld_value;
  mode_e            mode_q;
  logic             blank;
  logic [CNT_W-1:0] cnt;

  always_comb begin
    ld_value = D;
    unique case (op_e'(OP))
      OP_WRITE:  ld_value = D;
      OP_SET:    ld_value = pattern | D;
      OP_CLEAR:  ld_value = pattern & ~D;
      OP_TOGGLE: ld_value = pattern ^ D;
    endcase
  end

  // NOTE: every register below is written with <= so that all of them sample
  // the pre-edge values; blocking assignments here would let a tick or mode
  // change leak into other registers within the same edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      pattern <= RESET_VAL;
      mode_q  <= M_STATIC;
      blank   <= 1'b0;
      cnt     <= '0;
      tick    <= 1'b0;
    end else begin
      // Prescaler restarts on a mode change so the new mode gets a full period.
      tick <= (cnt == CNT_MAX);
      if (MODE_LD || cnt == CNT_MAX) cnt <= '0;
      else                           cnt <= cnt + CNT_W'(1);

      // A concurrent LD wins over the tick's rotation; the tick uses the old mode.
      if (LD) begin
        pattern <= ld_value;
      end else if (tick) begin
        unique case (mode_q)
          M_ROL:   pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]};
          M_ROR:   pattern <= {pattern[0], pattern[WIDTH-1:1]};
          default: pattern <= pattern;
        endcase
      end

      if (MODE_LD) begin
        mode_q <= mode_e'(MODE_D);
        blank  <= 1'b0;
      end else if (tick && mode_q == M_BLINK) begin
        blank <= ~blank;
      end
    end
  end

  assign led  = (mode_q == M_BLINK && blank) ? '0 : pattern;
  assign mode = mode_q;

endmodule

// File: tb/tb_led_pattern_ctrl.sv
// Directed bench for led_pattern_ctrl with TICK_DIV=4: table-driven LD ops
// plus hand-written sequences for tick timing, rotation, blink and collisions.
module tb_led_pattern_ctrl;

  localparam int W = 16;

  logic         clock = 1'b0;
  logic         reset;
  logic [W-1:0] D;
  logic         LD;
  logic [1:0]   OP;
  logic [1:0]   MODE_D;
  logic         MODE_LD;
  logic [W-1:0] led;
  logic [1:0]   mode;
  logic         tick;

  int n_checks = 0;
  int n_fail   = 0;

  led_pattern_ctrl #(
    .WIDTH(W), .RESET_VAL(16'h0001), .TICK_DIV(4), .CNT_W(2)
  ) dut (
    .clock(clock), .reset(reset), .D(D), .LD(LD), .OP(OP),
    .MODE_D(MODE_D), .MODE_LD(MODE_LD), .led(led), .mode(mode), .tick(tick)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic         ld;
    logic [1:0]   op;
    logic [W-1:0] d;
    logic [W-1:0] exp_led;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock edge; outputs are then sampled 1 time unit after it.
  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    LD = 1'b0; MODE_LD = 1'b0; OP = 2'b00; D = '0; MODE_D = 2'b00;
  endtask

  // Load a pattern and a mode in the same edge; prescaler restarts at 0.
  task automatic load_both(input logic [W-1:0] pat, input logic [1:0] m);
    LD = 1'b1; OP = 2'b00; D = pat; MODE_LD = 1'b1; MODE_D = m;
    cyc();
    idle();
  endtask

  vec_t vecs[8];

  initial begin
    vecs[0] = '{1'b1, 2'b00, 16'h00F0, 16'h00F0};
    vecs[1] = '{1'b1, 2'b01, 16'h0F00, 16'h0FF0};
    vecs[2] = '{1'b1, 2'b10, 16'h0030, 16'h0FC0};
    vecs[3] = '{1'b1, 2'b11, 16'hFFFF, 16'hF03F};
    vecs[4] = '{1'b1, 2'b00, 16'hA5A5, 16'hA5A5};
    vecs[5] = '{1'b0, 2'b11, 16'hFFFF, 16'hA5A5};
    vecs[6] = '{1'b1, 2'b10, 16'hFFFF, 16'h0000};
    vecs[7] = '{1'b1, 2'b01, 16'h8001, 16'h8001};

    // Reset held 2 cycles with a competing LD.
    reset = 1'b1; idle(); LD = 1'b1; D = 16'hFFFF;
    cyc(); cyc();
    check("reset_led", 32'(led), 32'h0001);
    check("reset_mode", 32'(mode), 32'd0);
    check("reset_tick", 32'(tick), 32'd0);
    reset = 1'b0; idle();

    // Ticks after edges 4 and 8 following release.
    for (int k = 1; k <= 8; k++) begin
      cyc();
      check($sformatf("first_tick_k%0d", k), 32'(tick), (k == 4 || k == 8) ? 32'd1 : 32'd0);
    end

    // LD operation table in static mode.
    for (int i = 0; i < 8; i++) begin
      LD = vecs[i].ld; OP = vecs[i].op; D = vecs[i].d;
      cyc();
      idle();
      check($sformatf("ld_vec%0d", i), 32'(led), 32'(vecs[i].exp_led));
    end

    // Rotate-left with wrap: 8001 -> 0003 -> 0006.
    load_both(16'h8001, 2'b01);
    check("rol_mode", 32'(mode), 32'd1);
    for (int k = 1; k <= 9; k++) begin
      cyc();
      check($sformatf("rol_k%0d", k), 32'(led),
            (k < 5) ? 32'h8001 : (k < 9) ? 32'h0003 : 32'h0006);
    end

    // Rotate-right with wrap: 0001 -> 8000.
    load_both(16'h0001, 2'b10);
    for (int k = 1; k <= 5; k++) begin
      cyc();
      check($sformatf("ror_k%0d", k), 32'(led), (k < 5) ? 32'h0001 : 32'h8000);
    end

    // Blink: visible 4 cycles, blanked 4, visible 4, blanked again.
    load_both(16'h00FF, 2'b11);
    for (int k = 1; k <= 13; k++) begin
      cyc();
      check($sformatf("blink_k%0d", k), 32'(led),
            (k < 5 || (k >= 9 && k < 13)) ? 32'h00FF : 32'h0000);
    end
    MODE_LD = 1'b1; MODE_D = 2'b00;
    cyc(); idle();
    check("unblank_static_led", 32'(led), 32'h00FF);
    check("unblank_static_mode", 32'(mode), 32'd0);

    // Re-entering blink while blanked clears blank.
    MODE_LD = 1'b1; MODE_D = 2'b11;
    cyc(); idle();
    for (int k = 1; k <= 5; k++) cyc();
    check("reblink_blanked", 32'(led), 32'h0000);
    MODE_LD = 1'b1; MODE_D = 2'b11;
    cyc(); idle();
    check("reblink_clears_blank", 32'(led), 32'h00FF);

    // LD on the tick cycle wins over the rotation.
    load_both(16'h0001, 2'b01);
    for (int k = 1; k <= 4; k++) cyc();
    check("coll_tick_high", 32'(tick), 32'd1);
    LD = 1'b1; OP = 2'b00; D = 16'h1234;
    cyc(); idle();
    check("coll_ld_wins", 32'(led), 32'h1234);
    for (int k = 6; k <= 9; k++) begin
      cyc();
      check($sformatf("coll_k%0d", k), 32'(led), (k < 9) ? 32'h1234 : 32'h2468);
    end

    // Reset in rotate mode at prescaler count 2.
    load_both(16'h0005, 2'b01);
    cyc(); cyc();
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("midrst_led", 32'(led), 32'h0001);
    check("midrst_mode", 32'(mode), 32'd0);
    check("midrst_tick", 32'(tick), 32'd0);
    for (int k = 1; k <= 4; k++) begin
      cyc();
      check($sformatf("midrst_tick_k%0d", k), 32'(tick), (k == 4) ? 32'd1 : 32'd0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/led_pattern_ctrl.md
Name: led_pattern_ctrl

Overview:
- Parametrised successor to the single-register LED latch.
- Holds a WIDTH-bit LED pattern that the TramelBlaze updates through an output port. Supported write operations are write, set, clear and toggle.
- Adds an autonomous animation engine with four modes: static, rotate-left, rotate-right and blink. The engine is paced by an internal prescaler.
- Sits between the TramelBlaze output-port decode and the board LED pins.

Parameters:
- WIDTH, 16, pattern and LED width (≥2).
- RESET_VAL, 16'h0001, pattern value after reset (WIDTH bits).
- TICK_DIV, 50_000_000, clock cycles per animation tick (≥2).
- CNT_W, 26, prescaler counter width; must satisfy 2^CNT_W ≥ TICK_DIV.

Ports:
- clock  in  1  system clock, rising-edge.
- reset  in  1  synchronous, active-high reset.
- D  in  WIDTH  write data for the pattern register.
- LD  in  1  one-cycle strobe: apply OP using D to the pattern.
- OP  in  2  00 write, 01 set (pattern|D), 10 clear (pattern&~D), 11 toggle (pattern^D).
- MODE_D  in  2  00 static, 01 rotate-left, 10 rotate-right, 11 blink.
- MODE_LD  in  1  one-cycle strobe: load MODE_D into the mode register.
- led  out  WIDTH  LED drive.
- mode  out  2  current mode register.
- tick  out  1  one-cycle pulse on each animation tick.

Behaviour:
- Clock and reset: one clock domain; reset is synchronous and active-high. All state updates on the rising edge of clock.
- Reset values:
  - pattern = RESET_VAL, mode = 00, prescaler = 0, blank = 0, tick = 0.
  - Therefore led = RESET_VAL on the first cycle after reset.
  - Reset overrides LD, MODE_LD and tick in the same cycle.
- Prescaler:
  - Counts 0..TICK_DIV-1, then wraps to 0.
  - tick is registered: high for exactly the one cycle after the counter held TICK_DIV-1.
  - Period is exactly TICK_DIV cycles.
  - Counter runs in every mode.
  - MODE_LD clears the counter to 0, so the first tick after a mode change arrives TICK_DIV cycles later. LD does not touch the counter.
- Pattern update priority per cycle: reset > LD > tick action > hold.
- LD: pattern <= f(OP, pattern, D), visible on led the following cycle.
- Tick action (only when tick=1 and LD=0):
  - 00 static: hold.
  - 01 rotate-left: pattern <= {pattern[WIDTH-2:0], pattern[WIDTH-1]}.
  - 10 rotate-right: pattern <= {pattern[0], pattern[WIDTH-1:1]}.
  - 11 blink: pattern holds; blank <= ~blank.
- Rotation wraps around; the MSB/LSB carries into the opposite end. Rotation of all-zeros or all-ones is stable.
- LD and tick in the same cycle: the LD result is taken and the rotation for that tick is dropped. For blink, blank still toggles (blank is independent of pattern).
- MODE_LD:
  - mode <= MODE_D and blank <= 0, effective the next cycle.
  - MODE_LD with LD in the same cycle: both apply.
  - MODE_LD with a tick in the same cycle: the tick action uses the old mode.
- Output:
  - led = (mode==11 && blank) ? 0 : pattern.
  - Decoded combinationally from registers only; no input-to-output combinational path.
- Mode output: mode reflects the register.
- No internal state beyond pattern, mode, blank, prescaler and tick.

Test Plan:
- Reset: assert reset 2 cycles with LD=1, D=16'hFFFF. Required: led=16'h0001, mode=0, tick=0. After release with TICK_DIV=4, the first tick pulse appears on cycle 4, then every 4 cycles.
- LD ops from pattern 16'h00F0:
  - OP=01, D=16'h0F00 → 16'h0FF0.
  - OP=10, D=16'h0030 → 16'h0FC0.
  - OP=11, D=16'hFFFF → 16'hF03F.
  - OP=00, D=16'hA5A5 → 16'hA5A5.
  - Each result appears on led one cycle after its LD.
- Rotate wrap (TICK_DIV=4): load 16'h8001, MODE_LD=01. Successive ticks → 16'h0003, 16'h0006. Mode 10 from 16'h0001 → 16'h8000 on the first tick.
- Blink (TICK_DIV=4): pattern 16'h00FF, MODE_LD=11. led=16'h00FF for 4 cycles, then 16'h0000 after the first tick, then 16'h00FF after the next. MODE_LD=00 while blanked → led=16'h00FF the next cycle.
- Collision: in mode 01 with pattern 16'h0001, pulse LD (OP=00, D=16'h1234) on the tick cycle. Required: pattern=16'h1234, unrotated. The next tick gives 16'h2468.
- Mid-operation reset: during rotate mode at prescaler count 2, assert reset for 1 cycle. Required: led=16'h0001, mode=0, counter=0, and the next tick arrives after TICK_DIV cycles.
